gameover_ctrl: RTL and testbench

Game-state controller that produces the `gameover` level consumed by the game-over LED animator. Tracks remaining lives, converts raw collision indications into single-cycle hits, and enforces a post-hit invulnerability window. It sits between the collision detection logic and the game-over LED display, and provides a start/restart handshake for the top level.

---
 rtl/gameover_ctrl.sv | 94 +++++++++
 tb/tb_gameover_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/gameover_ctrl.sv
// Game-state controller: life counting, collision edge detection, post-hit
// invulnerability window and the gameover level for the LED animator.
//
// state  | meaning
// IDLE   | waiting for start, lives parked at START_LIVES
// PLAY   | collisions counted as hits
// INVULN | post-hit window, cooldown down-counter running
// OVER   | no lives left, gameover held until restart
module gameover_ctrl #(
  parameter int START_LIVES     = 3,
  parameter int COOLDOWN_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       collision,
  output logic [2:0] lives,
  output logic       hit,
  output logic       invuln,
  output logic       gameover
);

  typedef enum logic [1:0] {IDLE, PLAY, INVULN, OVER} state_t;

  localparam logic [2:0]  LIVES_INIT = 3'(START_LIVES);
  localparam logic [27:0] CNT_LOAD   = 28'(COOLDOWN_CYCLES - 1);

  state_t      state;
  logic [27:0] cooldown_cnt;
  logic        collision_q;
  logic        rise;

  assign rise = collision & ~collision_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      lives        <= LIVES_INIT;
      hit          <= 1'b0;
      invuln       <= 1'b0;
      gameover     <= 1'b0;
      cooldown_cnt <= 28'd0;
      collision_q  <= 1'b0;
    end else begin
      // history tracks the input in every state so a held collision never
      // looks like a new edge once play resumes
      collision_q <= collision;
      hit         <= 1'b0;
      case (state)
        IDLE: begin
          lives    <= LIVES_INIT;
          invuln   <= 1'b0;
          gameover <= 1'b0;
          if (start) state <= PLAY;
        end
        PLAY: begin
          if (rise && !pause && lives != 3'd0) begin
            hit   <= 1'b1;
            lives <= lives - 3'd1;
            if (lives == 3'd1) begin
              state    <= OVER;
              gameover <= 1'b1;
            end else begin
              state        <= INVULN;
              invuln       <= 1'b1;
              cooldown_cnt <= CNT_LOAD;
            end
          end
        end
        INVULN: begin
          if (!pause) begin
            if (cooldown_cnt == 28'd0) begin
              state  <= PLAY;
              invuln <= 1'b0;
            end else begin
              cooldown_cnt <= cooldown_cnt - 28'd1;
            end
          end
        end
        OVER: begin
          lives <= 3'd0;
          if (start) begin
            state    <= IDLE;
            gameover <= 1'b0;
            lives    <= LIVES_INIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gameover_ctrl.sv
// Scoreboard bench for gameover_ctrl with START_LIVES=3, COOLDOWN_CYCLES=4.
module tb_gameover_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       pause;
  logic       collision;
  logic [2:0] lives;
  logic       hit;
  logic       invuln;
  logic       gameover;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [2:0] lives;
    logic       hit;
    logic       invuln;
    logic       gameover;
  } exp_t;

  exp_t sb[$];

  gameover_ctrl #(.START_LIVES(3), .COOLDOWN_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pause     (pause),
    .collision (collision),
    .lives     (lives),
    .hit       (hit),
    .invuln    (invuln),
    .gameover  (gameover)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] l,
                            input logic h, input logic i, input logic g);
    chk({tag, "_lives"},    int'(lives),    int'(l));
    chk({tag, "_hit"},      int'(hit),      int'(h));
    chk({tag, "_invuln"},   int'(invuln),   int'(i));
    chk({tag, "_gameover"}, int'(gameover), int'(g));
  endtask

  // drive one cycle of inputs, queue the outputs expected after the edge,
  // then compare against what the DUT shows just after that edge
  task automatic step(input string tag, input logic s, input logic p,
                      input logic c, input logic [2:0] l, input logic h,
                      input logic i, input logic g);
    exp_t e;
    start     = s;
    pause     = p;
    collision = c;
    e.tag = tag; e.lives = l; e.hit = h; e.invuln = i; e.gameover = g;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_outs(e.tag, e.lives, e.hit, e.invuln, e.gameover);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; collision = 1'b0;
    #3;
    check_outs("rst", 3'd3, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // basic hit and invulnerability window
    step("idle",   0, 0, 0, 3'd3, 0, 0, 0);
    step("start",  1, 0, 0, 3'd3, 0, 0, 0);
    step("play",   0, 0, 0, 3'd3, 0, 0, 0);
    step("hit1",   0, 0, 1, 3'd2, 1, 1, 0);
    step("inv1",   0, 0, 0, 3'd2, 0, 1, 0);
    step("inv2",   0, 0, 0, 3'd2, 0, 1, 0);
    step("invrise",0, 0, 1, 3'd2, 0, 1, 0);
    step("invend", 0, 0, 1, 3'd2, 0, 0, 0);
    step("held",   0, 0, 1, 3'd2, 0, 0, 0);
    step("low",    0, 0, 0, 3'd2, 0, 0, 0);
    step("hit2",   0, 0, 1, 3'd1, 1, 1, 0);
    for (int k = 0; k < 3; k++) step("inv_b", 0, 0, 0, 3'd1, 0, 1, 0);
    step("invend2",0, 0, 0, 3'd1, 0, 0, 0);

    // rise while paused in PLAY is lost, not deferred
    step("prise",  0, 1, 1, 3'd1, 0, 0, 0);
    step("unpause",0, 0, 1, 3'd1, 0, 0, 0);
    step("low2",   0, 0, 0, 3'd1, 0, 0, 0);

    // final hit and held gameover
    step("hit3",   0, 0, 1, 3'd0, 1, 0, 1);
    step("over",   0, 0, 0, 3'd0, 0, 0, 1);
    for (int k = 0; k < 100; k++)
      step("overhold", 0, 0, 1'($urandom_range(0, 1)), 3'd0, 0, 0, 1);

    // restart: two edges with start held
    step("restart1", 1, 0, 0, 3'd3, 0, 0, 0);
    step("restart2", 1, 0, 0, 3'd3, 0, 0, 0);
    step("rplay",    0, 0, 0, 3'd3, 0, 0, 0);

    // pause mid-INVULN stretches the window to 4+10 cycles
    step("phit",   0, 0, 1, 3'd2, 1, 1, 0);
    step("pinv",   0, 0, 0, 3'd2, 0, 1, 0);
    for (int k = 0; k < 10; k++)
      step("paused", 0, 1, 1'(k % 2), 3'd2, 0, 1, 0);
    step("pinv2",  0, 0, 0, 3'd2, 0, 1, 0);
    step("pinv3",  0, 0, 0, 3'd2, 0, 1, 0);
    step("pend",   0, 0, 0, 3'd2, 0, 0, 0);

    // async reset mid-INVULN
    step("ahit",   0, 0, 1, 3'd1, 1, 1, 0);
    step("ainv",   0, 0, 0, 3'd1, 0, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    check_outs("arst", 3'd3, 1'b0, 1'b0, 1'b0);
    #1;
    reset = 1'b0;
    step("aidle",  0, 0, 0, 3'd3, 0, 0, 0);
    step("astart", 1, 0, 0, 3'd3, 0, 0, 0);
    step("ahit2",  0, 0, 1, 3'd2, 1, 1, 0);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
